// File: rtl/inbox_fifo_pkg.sv
// inbox_fifo_pkg: shared data-word width and default queue depth for the inbox FIFO
package inbox_fifo_pkg;
   localparam int DATA_WIDTH    = 8;
   localparam int DEFAULT_DEPTH = 16;
endpackage

// File: rtl/fifo_regfile.sv
// fifo_regfile: DEPTH x WIDTH storage, one synchronous write port, one asynchronous read port, no reset
// Ports: clk; we/waddr/wdata write port; raddr/rdata combinational read port.
module fifo_regfile #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   always_ff @(posedge clk)
      if (we) mem_q[waddr] <= wdata;
   assign rdata = mem_q[raddr];
endmodule

// File: rtl/inbox_fifo.sv
// inbox_fifo: first-word-fall-through input queue feeding the INBOX instruction
// Ports: clk, i_rst_n (async active-low); clr sync flush; wr/data_in push side with full;
// rIn pop strobe with data_out head word and inEmpty; count occupancy; ovf/udf sticky error flags.
module inbox_fifo
   import inbox_fifo_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int WIDTH = DATA_WIDTH
) (
   input  logic                     clk,
   input  logic                     i_rst_n,
   input  logic                     clr,
   input  logic                     wr,
   input  logic [WIDTH-1:0]         data_in,
   output logic                     full,
   input  logic                     rIn,
   output logic [WIDTH-1:0]         data_out,
   output logic                     inEmpty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf,
   output logic                     udf
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d, udf_q, udf_d;
   logic          push, pop;
   assign full    = count_q == CW'(DEPTH);
   assign inEmpty = count_q == '0;
   assign count   = count_q;
   assign ovf     = ovf_q;
   assign udf     = udf_q;
   // A pop frees the slot a full-cycle push writes into, so push is allowed when full if rIn is high.
   assign push = !clr && wr && (!full || rIn);
   assign pop  = !clr && rIn && !inEmpty;
   always_comb begin
      wr_ptr_d = clr ? '0 : wr_ptr_q + AW'(push);
      rd_ptr_d = clr ? '0 : rd_ptr_q + AW'(pop);
      count_d  = clr ? '0 : count_q + CW'(push) - CW'(pop);
      ovf_d    = !clr && (ovf_q || (wr && !push));
      udf_d    = !clr && (udf_q || (rIn && inEmpty));
   end
   always_ff @(posedge clk or negedge i_rst_n)
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   fifo_regfile #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata (data_in),
      .raddr (rd_ptr_q),
      .rdata (data_out)
   );
`ifdef FORMAL
   always_comb begin
      assert (count_q <= CW'(DEPTH));
      assert (count_q == CW'(DEPTH) || count_q[AW-1:0] == AW'(wr_ptr_q - rd_ptr_q));
      assert (!(inEmpty && full));
   end
`endif
endmodule

// File: tb/tb_inbox_fifo.sv
// tb_inbox_fifo: directed table-driven bench for inbox_fifo plus multi-cycle corner sequences
module tb_inbox_fifo;
   logic       clk = 1'b0, i_rst_n = 1'b0, clr = 1'b0, wr = 1'b0, rin = 1'b0;
   logic [7:0] data_in = '0, data_out;
   logic       full, in_empty, ovf, udf;
   logic [4:0] count;
   int         checks = 0, errors = 0;
   typedef struct {
      logic       wr, rin, clr;
      logic [7:0] din;
      logic [4:0] cnt;
      logic       emp, ful, ovf, udf, chk_d;
      logic [7:0] dout;
      string      name;
   } vec_t;
   vec_t v[$];
   byte unsigned model[$];
   always #5 clk = ~clk;
   inbox_fifo dut (
      .clk(clk), .i_rst_n(i_rst_n), .clr(clr), .wr(wr), .data_in(data_in), .full(full),
      .rIn(rin), .data_out(data_out), .inEmpty(in_empty), .count(count), .ovf(ovf), .udf(udf)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
      wr = w; rin = r; clr = c; data_in = d;
      @(posedge clk); #1;
      wr = 1'b0; rin = 1'b0; clr = 1'b0;
   endtask
   function automatic void add(input logic w, input logic r, input logic c, input logic [7:0] d,
                               input logic [4:0] n, input logic e, input logic f, input logic o,
                               input logic u, input logic cd, input logic [7:0] dv, input string nm);
      v.push_back('{w, r, c, d, n, e, f, o, u, cd, dv, nm});
   endfunction
   initial begin
      add(1,0,0,8'h05, 1,0,0,0,0, 1,8'h05, "push05");
      add(1,0,0,8'h12, 2,0,0,0,0, 1,8'h05, "push12");
      add(1,0,0,8'h7F, 3,0,0,0,0, 1,8'h05, "push7f");
      add(0,1,0,8'h00, 2,0,0,0,0, 1,8'h12, "pop1");
      add(0,1,0,8'h00, 1,0,0,0,0, 1,8'h7F, "pop2");
      add(0,1,0,8'h00, 0,1,0,0,0, 0,8'h00, "pop3");
      for (int k = 0; k < 16; k++)
         add(1,0,0,8'(k), 5'(k+1),0,k==15,0,0, 1,8'h00, "fill");
      add(1,0,0,8'hAA, 16,0,1,1,0, 1,8'h00, "push_full");
      add(1,1,0,8'hBB, 16,0,1,1,0, 1,8'h01, "full_wr_rd");
      for (int j = 1; j <= 15; j++)
         add(0,1,0,8'h00, 5'(16-j),0,0,1,0, 1, j <= 14 ? 8'(j+1) : 8'hBB, "drain");
      add(0,1,0,8'h00, 0,1,0,1,0, 0,8'h00, "drain_last");
      add(1,1,0,8'h33, 1,0,0,1,1, 1,8'h33, "empty_wr_rd");
      add(0,0,1,8'h00, 0,1,0,0,0, 0,8'h00, "clr");
      #2;
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(in_empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_ovf", 32'(ovf), 0);
      chk("rst_udf", 32'(udf), 0);
      @(negedge clk) i_rst_n = 1'b1;
      @(posedge clk); #1;
      foreach (v[i]) begin
         step(v[i].wr, v[i].rin, v[i].clr, v[i].din);
         chk({v[i].name, "_count"}, 32'(count), 32'(v[i].cnt));
         chk({v[i].name, "_empty"}, 32'(in_empty), 32'(v[i].emp));
         chk({v[i].name, "_full"}, 32'(full), 32'(v[i].ful));
         chk({v[i].name, "_ovf"}, 32'(ovf), 32'(v[i].ovf));
         chk({v[i].name, "_udf"}, 32'(udf), 32'(v[i].udf));
         if (v[i].chk_d) chk({v[i].name, "_dout"}, 32'(data_out), 32'(v[i].dout));
      end
      begin
         int pushed = 0, popped = 0;
         for (int i = 0; i < 400 && popped < 40; i++) begin
            logic w, r;
            w = pushed < 40 && i % 4 != 3;
            r = (i % 2 == 0 || pushed == 40) && model.size() > 0;
            if (r) chk("wrap_dout", 32'(data_out), 32'(model[0]));
            step(w, r, 0, 8'(8'h40 + pushed));
            if (r) begin void'(model.pop_front()); popped++; end
            if (w && (model.size() < 16 || r)) begin model.push_back(8'(8'h40 + pushed)); pushed++; end
            chk("wrap_count", 32'(count), 32'(model.size()));
            if (count > 16) chk("wrap_bound", 32'(count), 16);
         end
         chk("wrap_done", 32'(popped), 40);
         chk("wrap_ovf", 32'(ovf), 0);
      end
      step(0, 1, 0, 8'h00);
      chk("udf_set", 32'(udf), 1);
      for (int k = 0; k < 5; k++) step(1, 0, 0, 8'(8'h20 + k));
      chk("five_count", 32'(count), 5);
      step(1, 0, 1, 8'hEE);
      chk("clrwr_count", 32'(count), 0);
      chk("clrwr_empty", 32'(in_empty), 1);
      chk("clrwr_udf", 32'(udf), 0);
      chk("clrwr_ovf", 32'(ovf), 0);
      step(1, 0, 0, 8'h44);
      chk("after_clr_dout", 32'(data_out), 32'h44);
      for (int k = 0; k < 3; k++) step(1, 0, 0, 8'(8'h61 + k));
      chk("prerst_count", 32'(count), 4);
      #2 i_rst_n = 1'b0;
      #1;
      chk("async_count", 32'(count), 0);
      chk("async_empty", 32'(in_empty), 1);
      chk("async_full", 32'(full), 0);
      @(negedge clk) i_rst_n = 1'b1;
      @(posedge clk); #1;
      step(1, 0, 0, 8'h99);
      chk("postrst_dout", 32'(data_out), 32'h99);
      chk("postrst_count", 32'(count), 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
